hazard_forward_ctrl: RTL

- Stateful successor to the combinational forwarding unit in the MIPS32 pipeline.
- Tracks destination/write/load info of instructions in EX, MEM and WB in internal shadow registers.
- Generates EX-stage and ID-stage forward selects, load-use and branch-use stalls, and whole-pipe freeze on data-memory wait.
- Parametrised in register-address width; suppresses forwarding from register 0. Sits beside the pipeline registers and drives the EX/ID operand muxes, the PC/IF-ID hold and the ID/EX bubble.

---
 rtl/hazard_forward_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// Stateful hazard / forwarding controller for the MIPS32 pipeline.
// Optional counters enabled by defining HAZARD_STATS_EN.
module hazard_forward_ctrl #(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              validID,
   input  logic [REG_AW-1:0] rsID,
   input  logic [REG_AW-1:0] rtID,
   input  logic              useRsID,
   input  logic              useRtID,
   input  logic              branchID,
   input  logic [REG_AW-1:0] destRegID,
   input  logic              regWriteID,
   input  logic              memReadID,
   input  logic              memWait,
   output logic [1:0]        forwardRS,
   output logic [1:0]        forwardRT,
   output logic [1:0]        forwardRSID,
   output logic [1:0]        forwardRTID,
   output logic              stall,
   output logic              bubble,
   output logic              freeze
`ifdef HAZARD_STATS_EN
   ,
   input  logic              statClear,
   output logic [31:0]       stallCount,
   output logic [31:0]       freezeCount,
   output logic [31:0]       fwdCount
`endif
);

   localparam logic [REG_AW-1:0] ZERO = REG_AW'(ZERO_REG);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dest;
      logic              regWrite;
      logic              memRead;
   } slot_t;

   slot_t             exSlot;
   slot_t             memSlot;
   logic              wbValid;
   logic [REG_AW-1:0] wbDest;
   logic              wbRegWrite;
   logic [REG_AW-1:0] exRs;
   logic [REG_AW-1:0] exRt;
   logic              exUseRs;
   logic              exUseRt;
   // Low from reset until the first edge after release; gates every output.
   logic              live;

   logic [1:0] fwdRs;
   logic [1:0] fwdRt;
   logic [1:0] fwdRsId;
   logic [1:0] fwdRtId;
   logic       idRsUse;
   logic       idRtUse;
   logic       exHit;
   logic       memHit;
   logic       hazard;
   logic       frz;
   logic       bub;
   logic       stl;

   function automatic logic writes(
      input logic              v,
      input logic              w,
      input logic [REG_AW-1:0] d,
      input logic [REG_AW-1:0] r
   );
      return v & w & (d == r) & (r != ZERO);
   endfunction

   function automatic logic [1:0] pick(
      input logic use_,
      input logic near,
      input logic far
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_ && near)
         sel = 2'b01;
      else if (use_ && far)
         sel = 2'b10;
      return sel;
   endfunction

   always_comb begin
      fwdRs   = 2'b00;
      fwdRt   = 2'b00;
      fwdRsId = 2'b00;
      fwdRtId = 2'b00;
      idRsUse = validID & useRsID;
      idRtUse = validID & useRtID;

      fwdRs = pick(exUseRs,
         writes(memSlot.valid, memSlot.regWrite, memSlot.dest, exRs),
         writes(wbValid, wbRegWrite, wbDest, exRs));
      fwdRt = pick(exUseRt,
         writes(memSlot.valid, memSlot.regWrite, memSlot.dest, exRt),
         writes(wbValid, wbRegWrite, wbDest, exRt));
      fwdRsId = pick(idRsUse,
         writes(exSlot.valid, exSlot.regWrite, exSlot.dest, rsID),
         writes(memSlot.valid, memSlot.regWrite, memSlot.dest, rsID));
      fwdRtId = pick(idRtUse,
         writes(exSlot.valid, exSlot.regWrite, exSlot.dest, rtID),
         writes(memSlot.valid, memSlot.regWrite, memSlot.dest, rtID));

      exHit =
         (idRsUse & writes(exSlot.valid, exSlot.regWrite, exSlot.dest, rsID)) |
         (idRtUse & writes(exSlot.valid, exSlot.regWrite, exSlot.dest, rtID));
      memHit =
         (idRsUse & writes(memSlot.valid, memSlot.regWrite, memSlot.dest, rsID)) |
         (idRtUse & writes(memSlot.valid, memSlot.regWrite, memSlot.dest, rtID));

      hazard = (exSlot.memRead & exHit) |
               (validID & branchID & (exHit | (memSlot.memRead & memHit)));

      frz = live & memWait;
      bub = live & hazard & ~memWait;
      stl = live & (memWait | hazard);
   end

   assign forwardRS   = live ? fwdRs   : 2'b00;
   assign forwardRT   = live ? fwdRt   : 2'b00;
   assign forwardRSID = live ? fwdRsId : 2'b00;
   assign forwardRTID = live ? fwdRtId : 2'b00;
   assign stall       = stl;
   assign bubble      = bub;
   assign freeze      = frz;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         live       <= 1'b0;
         exSlot     <= '0;
         memSlot    <= '0;
         wbValid    <= 1'b0;
         wbDest     <= '0;
         wbRegWrite <= 1'b0;
         exRs       <= '0;
         exRt       <= '0;
         exUseRs    <= 1'b0;
         exUseRt    <= 1'b0;
      end else begin
         live <= 1'b1;
         if (!frz) begin
            wbValid    <= memSlot.valid;
            wbDest     <= memSlot.dest;
            wbRegWrite <= memSlot.regWrite;
            memSlot    <= exSlot;
            if (validID && !bub) begin
               exSlot  <= '{1'b1, destRegID, regWriteID, memReadID};
               exRs    <= rsID;
               exRt    <= rtID;
               exUseRs <= useRsID;
               exUseRt <= useRtID;
            end else begin
               exSlot  <= '0;
               exRs    <= '0;
               exRt    <= '0;
               exUseRs <= 1'b0;
               exUseRt <= 1'b0;
            end
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic fwdAny;
   assign fwdAny = |{forwardRS, forwardRT, forwardRSID, forwardRTID};

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         stallCount  <= '0;
         freezeCount <= '0;
         fwdCount    <= '0;
      end else if (statClear) begin
         stallCount  <= '0;
         freezeCount <= '0;
         fwdCount    <= '0;
      end else begin
         if (stl && !frz && stallCount != '1)
            stallCount <= stallCount + 32'd1;
         if (frz && freezeCount != '1)
            freezeCount <= freezeCount + 32'd1;
         if (fwdAny && fwdCount != '1)
            fwdCount <= fwdCount + 32'd1;
      end
   end
`endif

endmodule
